nor_equiv_checker: RTL and testbench
====================================

Name: nor_equiv_checker

Overview:
- Self-test sequencer for the NOR gate library.
- Sweeps every input combination of an N-input NOR into two implementations in parallel: the direct N-input gate (reference) and the cascaded 2-input-gate version (under test).
- Compares their outputs one vector at a time and reports the mismatch count, the first failing vector, and pass/fail.
- Sits beside the gate instances on the bench/BIST wrapper and drives their shared inputs.

Parameters:
- N, 3: number of gate inputs; sweep covers 2^N vectors; legal range 2..8.
- SETTLE, 1: cycles each vector is held before sampling; must be >= 1.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a full sweep; sampled only in IDLE
- ref_out  input  1  output of the reference (direct N-input) NOR
- dut_out  input  1  output of the cascaded 2-input NOR implementation
- vec  output  N  input vector driven to both implementations, bit 0 = first gate input
- busy  output  1  high while a sweep is in progress
- done  output  1  sticky; sweep complete, cleared by next accepted start or rst
- pass  output  1  high only when done=1 and err_count=0
- err_count  output  N+1  number of mismatching vectors in the last sweep
- first_fail_vec  output  N  vec value of the first mismatch
- first_fail_valid  output  1  first_fail_vec holds a captured value

Behaviour:
- Reset (async, rst=1): FSM=IDLE; vec=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0; settle counter=0. Takes effect immediately, mid-sweep included; no partial results are retained.
- All outputs are registered; none are combinational from inputs.
- FSM states:
  - IDLE: start=1 at an edge -> SETTLE. On that same edge: vec=0, settle counter=0, err_count=0, first_fail_valid=0, first_fail_vec=0, done=0, pass=0, busy=1.
  - SETTLE: each edge increments the settle counter. When counter==SETTLE-1 -> COMPARE, counter=0. ref_out/dut_out are ignored here, so glitches during settling are never counted.
  - COMPARE (one edge): mismatch = ref_out XOR dut_out.
    - If mismatch: err_count += 1. If first_fail_valid=0, also first_fail_vec=vec and first_fail_valid=1.
    - If vec == 2^N-1: -> IDLE, busy=0, done=1, pass = (final err_count == 0), with the increment from this edge included.
    - Otherwise: vec += 1 -> SETTLE.
- Per-vector cost is SETTLE+1 edges. done rises exactly 2^N*(SETTLE+1) edges after the edge that accepted start. Example: N=3, SETTLE=1 gives 16.
- vec changes only on the accept edge and on COMPARE edges. It holds its last value (2^N-1) after done until the next accepted start.
- err_count cannot overflow: its maximum is 2^N, which fits in N+1 bits.
- start while busy=1: ignored; no restart, no status change.
- start held high continuously: a new sweep begins on the first edge in IDLE after done. done/pass/err_count are cleared on that edge, so results are visible for at least one cycle.
- done and pass stay stable in IDLE until the next accepted start.

Test Plan:
1. Reset: assert rst mid-cycle with random inputs -> all outputs 0 immediately (before the next clk edge); FSM idle, start accepted afterwards.
2. Matching gates, N=3, SETTLE=1, one-cycle start pulse -> busy high 16 cycles; vec steps 0..7, each value held 2 cycles; done=1, pass=1, err_count=0, first_fail_valid=0 on cycle 16.
3. dut_out stuck-at-0 (real NOR is 1 only at vec=0) -> err_count=1, first_fail_vec=0, first_fail_valid=1, pass=0, done=1 after 16 cycles.
4. dut_out stuck-at-1 -> mismatch at vec 1..7: err_count=7, first_fail_vec=1, pass=0. Also with SETTLE=3: done at cycle 32, and a dut_out glitch injected only during SETTLE cycles is not counted.
5. start pulsed again at vec=5 while busy -> ignored, sweep completes normally at cycle 16. New start after done -> done/pass/err_count cleared on the accept edge, vec=0, full rerun.
6. rst pulsed while vec=4 with err_count=2 -> all outputs 0. Subsequent start sweeps from vec=0, and err_count reflects only the new run.

Source files
------------

// File: rtl/nor_equiv_checker.sv
// nor_equiv_checker: self-test sequencer for the NOR gate library.
// Sweeps every N-bit input vector into a reference N-input NOR and a cascaded
// 2-input NOR build, compares the two outputs per vector, and reports the
// mismatch count, the first failing vector and an overall pass flag.
//
// Handshake: start is a level request sampled only while idle; a sweep runs
// to completion and cannot be restarted while busy=1. done is sticky and
// results stay stable until the next accepted start or rst.
module nor_equiv_checker #(
   parameter int N      = 3,
   parameter int SETTLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         ref_out,
   input  logic         dut_out,
   output logic [N-1:0] vec,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic [N:0]   err_count,
   output logic [N-1:0] first_fail_vec,
   output logic         first_fail_valid,
   output logic [1:0]   dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SETTLE  = 2'd1,
      S_COMPARE = 2'd2
   } state_t;

   // A width of at least one bit keeps SETTLE=1 legal.
   localparam int            CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [N-1:0]  r_vec;
   logic          r_busy;
   logic          r_done;
   logic          r_pass;
   logic [N:0]    r_err;
   logic [N-1:0]  r_ffv;
   logic          r_ffvalid;

   logic          w_mismatch;
   logic          w_last;
   logic [N:0]    w_err_next;

   // Compare results are only consumed in COMPARE, so settling glitches never count.
   assign w_mismatch = ref_out ^ dut_out;
   assign w_last     = (r_vec == {N{1'b1}});
   assign w_err_next = r_err + {{N{1'b0}}, w_mismatch};

   // Sweep sequencer: accept start, settle each vector, compare, advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_vec     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
         r_err     <= '0;
         r_ffv     <= '0;
         r_ffvalid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state   <= S_SETTLE;
                  r_vec     <= '0;
                  r_cnt     <= '0;
                  r_err     <= '0;
                  r_ffv     <= '0;
                  r_ffvalid <= 1'b0;
                  r_done    <= 1'b0;
                  r_pass    <= 1'b0;
                  r_busy    <= 1'b1;
               end
            end
            S_SETTLE: begin
               if (r_cnt == CNT_LAST) begin
                  r_cnt   <= '0;
                  r_state <= S_COMPARE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_COMPARE: begin
               r_err <= w_err_next;
               if (w_mismatch && !r_ffvalid) begin
                  r_ffv     <= r_vec;
                  r_ffvalid <= 1'b1;
               end
               if (w_last) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (w_err_next == '0);
               end else begin
                  r_vec   <= r_vec + 1'b1;
                  r_state <= S_SETTLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign vec              = r_vec;
   assign busy             = r_busy;
   assign done             = r_done;
   assign pass             = r_pass;
   assign err_count        = r_err;
   assign first_fail_vec   = r_ffv;
   assign first_fail_valid = r_ffvalid;
   assign dbg_state        = r_state;

endmodule

// File: tb/tb_nor_equiv_checker.sv
// Directed bench for nor_equiv_checker: two instances (SETTLE=1 and SETTLE=3)
// driven from behavioural NOR models with selectable faults.
module tb_nor_equiv_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_a, start_b;
   logic       ref_a, dut_a, ref_b, dut_b;
   logic [2:0] vec_a, vec_b, ffv_a, ffv_b;
   logic [3:0] err_a, err_b;
   logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
   logic       ffvalid_a, ffvalid_b;
   logic [1:0] dbg_a, dbg_b;

   int mode_a;   // 0 good, 1 stuck-0, 2 stuck-1, 3 wrong at vec 1 and 3
   int mode_b;   // 0 good, 1 inverted only while settling
   int which;    // 0 selects instance a, 1 selects instance b
   int checks = 0;
   int errors = 0;

   logic [2:0] s_vec, s_ffv;
   logic [3:0] s_err;
   logic       s_busy, s_done, s_pass, s_ffvalid;

   // clock
   always #5 clk = ~clk;

   nor_equiv_checker #(.N(3), .SETTLE(1)) u_a (
      .clk(clk), .rst(rst), .start(start_a), .ref_out(ref_a), .dut_out(dut_a),
      .vec(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a),
      .err_count(err_a), .first_fail_vec(ffv_a), .first_fail_valid(ffvalid_a),
      .dbg_state(dbg_a)
   );

   nor_equiv_checker #(.N(3), .SETTLE(3)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .ref_out(ref_b), .dut_out(dut_b),
      .vec(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b),
      .err_count(err_b), .first_fail_vec(ffv_b), .first_fail_valid(ffvalid_b),
      .dbg_state(dbg_b)
   );

   // gate models driven by the vectors
   always_comb begin
      ref_a = ~|vec_a;
      case (mode_a)
         1:       dut_a = 1'b0;
         2:       dut_a = 1'b1;
         3:       dut_a = ref_a ^ ((vec_a == 3'd1) || (vec_a == 3'd3));
         default: dut_a = ref_a;
      endcase
      ref_b = ~|vec_b;
      dut_b = ref_b ^ ((mode_b == 1) && (dbg_b == 2'd1));
   end

   // observation mux for the sweep task
   always_comb begin
      s_vec     = (which == 1) ? vec_b     : vec_a;
      s_ffv     = (which == 1) ? ffv_b     : ffv_a;
      s_err     = (which == 1) ? err_b     : err_a;
      s_busy    = (which == 1) ? busy_b    : busy_a;
      s_done    = (which == 1) ? done_b    : done_a;
      s_pass    = (which == 1) ? pass_b    : pass_a;
      s_ffvalid = (which == 1) ? ffvalid_b : ffvalid_a;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_vec_a"}, vec_a, 0);
      chk({tag, "_busy_a"}, busy_a, 0);
      chk({tag, "_done_a"}, done_a, 0);
      chk({tag, "_pass_a"}, pass_a, 0);
      chk({tag, "_err_a"}, err_a, 0);
      chk({tag, "_ffv_a"}, ffv_a, 0);
      chk({tag, "_ffvalid_a"}, ffvalid_a, 0);
      chk({tag, "_done_b"}, done_b, 0);
      chk({tag, "_err_b"}, err_b, 0);
   endtask

   // Full sweep on one instance: pulse start, track vec/busy per edge, check results.
   task automatic sweep(input int w, input int settle, input int exp_err,
                        input int exp_ffv, input int exp_ffvalid, input bit poke_mid);
      int per;
      per   = settle + 1;
      which = w;
      @(negedge clk);
      if (w == 0) start_a = 1'b1; else start_b = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      chk("accept_vec", s_vec, 0);
      chk("accept_busy", s_busy, 1);
      chk("accept_done", s_done, 0);
      chk("accept_pass", s_pass, 0);
      chk("accept_err", s_err, 0);
      chk("accept_ffvalid", s_ffvalid, 0);
      for (int e = 1; e < 8 * per; e++) begin
         @(negedge clk);
         start_a = 1'b0;
         start_b = 1'b0;
         chk("run_vec", s_vec, e / per);
         chk("run_busy", s_busy, 1);
         chk("run_done", s_done, 0);
         if (poke_mid && e == 5 * per) begin
            if (w == 0) start_a = 1'b1; else start_b = 1'b1;
         end
      end
      @(negedge clk);
      chk("end_done", s_done, 1);
      chk("end_busy", s_busy, 0);
      chk("end_vec", s_vec, 7);
      chk("end_err", s_err, exp_err);
      chk("end_pass", s_pass, (exp_err == 0) ? 1 : 0);
      chk("end_ffv", s_ffv, exp_ffv);
      chk("end_ffvalid", s_ffvalid, exp_ffvalid);
      @(negedge clk);
      chk("hold_done", s_done, 1);
      chk("hold_vec", s_vec, 7);
      chk("hold_err", s_err, exp_err);
   endtask

   initial begin
      rst     = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      mode_a  = 0;
      mode_b  = 0;
      which   = 0;
      #1;
      chk_all_zero("por");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // matching gates, then stuck-at-0, then stuck-at-1 with an ignored mid-sweep start
      sweep(0, 1, 0, 0, 0, 1'b0);
      mode_a = 1;
      sweep(0, 1, 1, 0, 1, 1'b0);
      mode_a = 2;
      sweep(0, 1, 7, 1, 1, 1'b1);
      // rerun after done: accept edge clears results
      mode_a = 0;
      sweep(0, 1, 0, 0, 0, 1'b0);

      // long settle with glitches only while settling
      mode_b = 1;
      sweep(1, 3, 0, 0, 0, 1'b0);
      mode_b = 0;

      // reset mid-sweep at vec=4 with two errors logged
      which  = 0;
      mode_a = 3;
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (8) @(negedge clk);
      chk("mid_vec", vec_a, 4);
      chk("mid_err", err_a, 2);
      chk("mid_ffv", ffv_a, 1);
      chk("mid_ffvalid", ffvalid_a, 1);
      #2;
      rst     = 1'b1;
      start_a = 1'(($urandom_range(0, 1)));
      mode_a  = $urandom_range(0, 3);
      #1;
      chk_all_zero("async_rst");
      @(negedge clk);
      rst     = 1'b0;
      start_a = 1'b0;
      mode_a  = 0;
      sweep(0, 1, 0, 0, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
